// File: rtl/sync_pkg.sv
// Shared definitions for clock-domain-crossing receivers.
// Latency: none; this file holds only constants and types.
// Backpressure: not applicable.
package sync_pkg;

  localparam int MODE_4PH = 0;  // level request / level acknowledge
  localparam int MODE_2PH = 1;  // toggle request / toggle acknowledge

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } state_t;

endpackage

// File: rtl/hs_sync_rx_if.sv
// Foreign-side handshake plus local valid/ready output bus of the sync receiver.
// Latency: none; this is wiring only.
// Backpressure: out_ready throttles the buffer, and a full buffer withholds ack.
// Ports: req_async/data_async/ack face the sender; out_* and level face local logic.
interface hs_sync_rx_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  logic                   req_async;
  logic [WIDTH-1:0]       data_async;
  logic                   ack;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] level;

  modport slave (
    input  req_async, data_async, out_ready,
    output ack, out_valid, out_data, level
  );

  modport master (
    output req_async, data_async, out_ready,
    input  ack, out_valid, out_data, level
  );

endinterface

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser chain for asynchronous inputs.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; it samples every edge.
// Ports: clk, rst (sync, active-high, clears the chain), d (async in), q (synchronised out).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/hs_sync_rx.sv
// Destination side of a req/ack bus synchroniser feeding a small FWFT buffer.
// Latency: word is visible STAGES+1 edges after req_async changes; ack updates on the same edge.
// Backpressure: a full buffer or en=0 withholds ack; out_ready pops the head.
// Ports: clk, rst (sync, active-high), en (capture enable), bus (hs_sync_rx_if.slave).
module hs_sync_rx
  import sync_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int DEPTH  = 4,
  parameter int MODE   = MODE_4PH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  hs_sync_rx_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic             req_s;
  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             full, pending, capture, push, pop;

  sync_ff #(.STAGES(STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.req_async),
    .q   (req_s)
  );

  // Full is judged on the registered level, so a pop on this edge only frees
  // the slot for the following edge.
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = (level_q != '0) && bus.out_ready;
  assign capture = en && !full && pending;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    push    = 1'b0;
    // Toggle mode: a request is outstanding whenever req_s and ack disagree.
    // Level mode: only a fresh high request seen from IDLE is outstanding.
    pending = (MODE == MODE_2PH) ? (req_s ^ ack_q) : ((state_q == IDLE) && req_s);

    if (MODE == MODE_2PH) begin
      if (capture) begin
        push  = 1'b1;
        ack_d = req_s;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            state_d = WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!req_s && en) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  // data_async is held stable by the sender until it sees our ack, so it is
  // written directly without synchronisation.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.data_async;
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = mem[rd_ptr_q];
  assign bus.level     = level_q;

endmodule
